hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. It decides, every cycle, whether each pipeline register advances, holds, or is flushed.
- The datapath forwards from MEM/WB only, so this block stalls on any unresolved RAW dependency. It flushes on a taken branch resolved in MEM.
- It sequences the multi-cycle multiply/divide unit (MDU) through a start/done handshake with a timeout.
- It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

Parameters:
- FWD_EX_MEM, 0, 1 = datapath also forwards from EX/MEM; only loads in EX then cause a stall.
- MDU_TIMEOUT, 64, maximum cycles in MDU_WAIT before abort; must be at least 2.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- IF_ID_R1, IF_ID_R2  in  5 each  source registers of the instruction in ID
- IF_ID_UsesR1, IF_ID_UsesR2  in  1 each  source actually read
- ID_EX_Rd  in  5  destination of the instruction in EX
- ID_EX_RegWrite, ID_EX_MemRead  in  1 each  EX-stage instruction writes a register / is a load
- ID_EX_IsMdu  in  1  EX-stage instruction is mul/div
- EX_MEM_BranchTaken  in  1  branch/jump resolved taken in MEM
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- pc_write, if_id_write, id_ex_write  out  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert NOP
- ex_mem_bubble  out  1  insert NOP into EX/MEM while EX is held
- mdu_start, mdu_abort  out  1 each  single-cycle pulses to the MDU
- mdu_error  out  1  sticky; set on timeout
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- FSM states: RUN, MDU_WAIT. Reset puts the FSM in RUN and clears the timeout counter, mdu_error, stall_cnt and flush_cnt.
- Control outputs are combinational from state and inputs. Values during rst=1: all write enables 1, all flushes, bubble and pulses 0.
- Data hazard (haz), evaluated in RUN only. haz = ID_EX_RegWrite AND ID_EX_Rd != 0 AND ((UsesR1 AND R1 == Rd) OR (UsesR2 AND R2 == Rd)).
  - The whole term is additionally ANDed with ID_EX_MemRead when FWD_EX_MEM = 1.
- Priority, highest first:
  1. Flush: EX_MEM_BranchTaken = 1 gives if_id_flush = id_ex_flush = ex_mem_flush = 1 and all writes = 1.
     - In MDU_WAIT, additionally pulse mdu_abort for one cycle and go to RUN.
     - The instruction in EX is younger than the branch and is therefore discarded.
  2. MDU launch: RUN, ID_EX_IsMdu = 1, no flush.
     - Pulse mdu_start, go to MDU_WAIT, load the timeout counter with 0.
     - In that same cycle hold the pipe: pc_write = if_id_write = id_ex_write = 0, ex_mem_bubble = 1.
  3. MDU_WAIT while mdu_done = 0: same hold; increment the timeout counter.
     - When the counter reaches MDU_TIMEOUT-1: pulse mdu_abort, set mdu_error, go to RUN, release the pipe next cycle.
     - mdu_error stays set until rst.
  4. MDU_WAIT with mdu_done = 1: release in that cycle (all writes = 1, no bubble), go to RUN. A result held in EX proceeds to EX/MEM.
     - A mdu_done that arrives in the same cycle as a flush is ignored (flush wins).
  5. Data hazard (RUN): pc_write = if_id_write = 0, id_ex_flush = 1 (bubble into EX), for exactly one cycle.
     - Next cycle the producer is in MEM and haz re-evaluates with the new ID_EX values.
- ID_EX_IsMdu during MDU_WAIT is not re-launched. Re-launch is only possible after returning to RUN with a new instruction in EX.
- mdu_done while in RUN is ignored.
- stall_cnt increments on every cycle with pc_write = 0. flush_cnt increments on every cycle with ex_mem_flush = 1. Both saturate at all-ones.
- rst asserted mid-MDU_WAIT: FSM returns to RUN without an abort pulse; the MDU is reset by the same rst.

Decomposition:
- Shared core package holds:
  - state encoding enum (RUN = 0, MDU_WAIT = 1)
  - REG_ADDR_W = 5 and the x0 constant
- Sub-module sat_counter (parameter W; inc, rst, count), instantiated twice for stall_cnt and flush_cnt.
- The FSM, timeout counter and hazard compare stay in hazard_stall_ctrl.

Test Plan:
- ALU result dependency, FWD_EX_MEM = 0: ID_EX_RegWrite = 1, Rd = 5, IF_ID_R1 = 5, UsesR1 = 1 -> one cycle pc_write = 0, id_ex_flush = 1, stall_cnt = 1. Same stimulus with FWD_EX_MEM = 1 and MemRead = 0 -> no stall.
- Rd = 0 with R1 = 0 -> no stall. UsesR2 = 0 with R2 matching -> no stall.
- MDU op enters EX; mdu_done on the 4th wait cycle -> mdu_start pulse in cycle 0, pipe held 4 cycles (ex_mem_bubble = 1), released in the done cycle, stall_cnt = 4.
- MDU never completes, MDU_TIMEOUT = 8 -> mdu_abort pulse and mdu_error = 1 after 8 held cycles, FSM back to RUN, mdu_error persists until rst.
- Branch taken in MEM during MDU_WAIT, simultaneous with a pending hazard -> all three flushes = 1, mdu_abort pulse, no stall, flush_cnt = 1, RUN next cycle.
- Counter saturation with CNT_W = 4: 20 consecutive stall cycles -> stall_cnt = 15 and holds; rst -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   ctrlState_t  - sequencer state encoding (RUN = 0, MDU_WAIT = 1)
//   REG_ADDR_W   - register-file address width
//   REG_X0       - hard-wired zero register; never a real producer
//   srcMatch()   - true when a source operand is read and names the given destination
package hazard_stall_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } ctrlState_t;

   function automatic logic srcMatch(input logic                  uses,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - count this cycle
//   count - current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: stall on RAW hazards, flush on taken branches, sequence the MDU.
// Latency: control outputs are combinational from state and inputs; state, error and counters update next edge.
// Backpressure: holds PC/IF/ID/ID-EX while the MDU is busy; the MDU is bounded by a timeout and abort.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   IF_ID_R1/R2, IF_ID_UsesR1/R2      - source registers of the ID instruction and whether each is read
//   ID_EX_Rd, ID_EX_RegWrite,
//   ID_EX_MemRead, ID_EX_IsMdu        - the instruction currently in EX
//   EX_MEM_BranchTaken                - taken branch/jump resolved in MEM
//   mdu_done                          - MDU result valid pulse
//   pc_write, if_id_write, id_ex_write - pipeline register enables
//   if_id_flush, id_ex_flush, ex_mem_flush - NOP insertion
//   ex_mem_bubble                     - NOP into EX/MEM while EX is held
//   mdu_start, mdu_abort              - single-cycle MDU pulses
//   mdu_error                         - sticky timeout flag
//   stall_cnt, flush_cnt              - saturating event counters
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter bit FWD_EX_MEM  = 1'b0,
   parameter int MDU_TIMEOUT = 64,   // must be >= 2
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] IF_ID_R1,
   input  logic [REG_ADDR_W-1:0] IF_ID_R2,
   input  logic                  IF_ID_UsesR1,
   input  logic                  IF_ID_UsesR2,
   input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
   input  logic                  ID_EX_RegWrite,
   input  logic                  ID_EX_MemRead,
   input  logic                  ID_EX_IsMdu,
   input  logic                  EX_MEM_BranchTaken,
   input  logic                  mdu_done,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  ex_mem_bubble,
   output logic                  mdu_start,
   output logic                  mdu_abort,
   output logic                  mdu_error,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int TO_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

   ctrlState_t      state, nextState;
   logic [TO_W-1:0] toCnt, toCntNext;
   logic            errSet;
   logic            hazRaw, haz;

   // RAW dependency on the EX-stage producer. With EX/MEM forwarding only a
   // load can still be unresolved, since its data appears after MEM.
   assign hazRaw = ID_EX_RegWrite && (ID_EX_Rd != REG_X0) &&
                   (srcMatch(IF_ID_UsesR1, IF_ID_R1, ID_EX_Rd) ||
                    srcMatch(IF_ID_UsesR2, IF_ID_R2, ID_EX_Rd));
   assign haz    = hazRaw && (!FWD_EX_MEM || ID_EX_MemRead);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         toCnt     <= '0;
         mdu_error <= 1'b0;
      end else begin
         state <= nextState;
         toCnt <= toCntNext;
         if (errSet) begin
            mdu_error <= 1'b1;
         end
      end
   end

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      ex_mem_bubble = 1'b0;
      mdu_start     = 1'b0;
      mdu_abort     = 1'b0;
      errSet        = 1'b0;
      nextState     = state;
      toCntNext     = toCnt;

      if (rst) begin
         // The MDU is reset by the same rst, so no abort is needed here.
         nextState = RUN;
      end else if (EX_MEM_BranchTaken) begin
         // The EX instruction is younger than the branch; any MDU op there dies too.
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         if (state == MDU_WAIT) begin
            mdu_abort = 1'b1;
         end
         nextState = RUN;
      end else if (state == RUN) begin
         if (ID_EX_IsMdu) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mdu_start     = 1'b1;
            toCntNext     = '0;
            nextState     = MDU_WAIT;
         end else if (haz) begin
            // Bubble into EX; the producer moves on to MEM where it forwards.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end else begin
         // MDU_WAIT: a done pulse releases the pipe in the same cycle.
         if (mdu_done) begin
            nextState = RUN;
         end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            if (toCnt == TO_LAST) begin
               mdu_abort = 1'b1;
               errSet    = 1'b1;
               nextState = RUN;
            end else begin
               toCntNext = toCnt + TO_W'(1);
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) uStallCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!pc_write),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) uFlushCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ex_mem_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (no forwarding / EX-MEM forwarding)
// share stimulus; control vectors and counters are compared against hand-computed values.
// Clock period 10; inputs driven 1 after posedge, outputs sampled 2 later.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] r1, r2, rd;
   logic       usesR1, usesR2, regWrite, memRead, isMdu, brTaken, mduDone;

   logic       pcW0, ifW0, idW0, ifF0, idF0, exF0, bub0, st0, ab0, err0;
   logic       pcW1, ifW1, idW1, ifF1, idF1, exF1, bub1, st1, ab1, err1;
   logic [3:0] stall0, flush0, stall1, flush1;
   logic [8:0] ctrl0, ctrl1;

   int checks = 0;
   int errors = 0;

   // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush,
   //  ex_mem_bubble, mdu_start, mdu_abort}
   localparam logic [8:0] P_RUN    = 9'b111_000_000;
   localparam logic [8:0] P_HAZ    = 9'b001_010_000;
   localparam logic [8:0] P_LAUNCH = 9'b000_000_110;
   localparam logic [8:0] P_HOLD   = 9'b000_000_100;
   localparam logic [8:0] P_TOUT   = 9'b000_000_101;
   localparam logic [8:0] P_FLUSH  = 9'b111_111_000;
   localparam logic [8:0] P_FLUSHW = 9'b111_111_001;

   assign ctrl0 = {pcW0, ifW0, idW0, ifF0, idF0, exF0, bub0, st0, ab0};
   assign ctrl1 = {pcW1, ifW1, idW1, ifF1, idF1, exF1, bub1, st1, ab1};

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.FWD_EX_MEM(1'b0), .MDU_TIMEOUT(8), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst),
      .IF_ID_R1(r1), .IF_ID_R2(r2), .IF_ID_UsesR1(usesR1), .IF_ID_UsesR2(usesR2),
      .ID_EX_Rd(rd), .ID_EX_RegWrite(regWrite), .ID_EX_MemRead(memRead),
      .ID_EX_IsMdu(isMdu), .EX_MEM_BranchTaken(brTaken), .mdu_done(mduDone),
      .pc_write(pcW0), .if_id_write(ifW0), .id_ex_write(idW0),
      .if_id_flush(ifF0), .id_ex_flush(idF0), .ex_mem_flush(exF0),
      .ex_mem_bubble(bub0), .mdu_start(st0), .mdu_abort(ab0), .mdu_error(err0),
      .stall_cnt(stall0), .flush_cnt(flush0)
   );

   hazard_stall_ctrl #(.FWD_EX_MEM(1'b1), .MDU_TIMEOUT(8), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst),
      .IF_ID_R1(r1), .IF_ID_R2(r2), .IF_ID_UsesR1(usesR1), .IF_ID_UsesR2(usesR2),
      .ID_EX_Rd(rd), .ID_EX_RegWrite(regWrite), .ID_EX_MemRead(memRead),
      .ID_EX_IsMdu(isMdu), .EX_MEM_BranchTaken(brTaken), .mdu_done(mduDone),
      .pc_write(pcW1), .if_id_write(ifW1), .id_ex_write(idW1),
      .if_id_flush(ifF1), .id_ex_flush(idF1), .ex_mem_flush(exF1),
      .ex_mem_bubble(bub1), .mdu_start(st1), .mdu_abort(ab1), .mdu_error(err1),
      .stall_cnt(stall1), .flush_cnt(flush1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      r1 = 5'd0; r2 = 5'd0; rd = 5'd0;
      usesR1 = 1'b0; usesR2 = 1'b0; regWrite = 1'b0; memRead = 1'b0;
      isMdu = 1'b0; brTaken = 1'b0; mduDone = 1'b0;
   endtask

   initial begin
      // Reset: outputs forced to pass-through even with an MDU op present.
      rst = 1'b1;
      clearIn();
      isMdu = 1'b1;
      #2;
      chk("rst_ctrl", 16'(ctrl0), 16'(P_RUN));
      tick();
      chk("rst_stall", 16'(stall0), 16'd0);
      chk("rst_flush", 16'(flush0), 16'd0);
      chk("rst_err", 16'(err0), 16'd0);
      rst = 1'b0;
      clearIn();
      #2;
      chk("idle", 16'(ctrl0), 16'(P_RUN));
      tick();

      // ALU result dependency on R1.
      regWrite = 1'b1; rd = 5'd5; r1 = 5'd5; usesR1 = 1'b1;
      #2;
      chk("alu_haz_nofwd", 16'(ctrl0), 16'(P_HAZ));
      chk("alu_haz_fwd", 16'(ctrl1), 16'(P_RUN));
      tick();
      chk("alu_stall_cnt", 16'(stall0), 16'd1);
      chk("alu_stall_cnt_fwd", 16'(stall1), 16'd0);
      clearIn();
      #2;
      chk("after_bubble", 16'(ctrl0), 16'(P_RUN));
      tick();

      // x0 never hazards; unread R2 never hazards.
      regWrite = 1'b1; rd = 5'd0; r1 = 5'd0; usesR1 = 1'b1;
      #2;
      chk("x0_no_haz", 16'(ctrl0), 16'(P_RUN));
      tick();
      clearIn();
      regWrite = 1'b1; rd = 5'd7; r2 = 5'd7; usesR2 = 1'b0;
      #2;
      chk("r2_unused", 16'(ctrl0), 16'(P_RUN));
      tick();
      // Load-use on R2 stalls with and without forwarding.
      usesR2 = 1'b1; memRead = 1'b1;
      #2;
      chk("load_r2_nofwd", 16'(ctrl0), 16'(P_HAZ));
      chk("load_r2_fwd", 16'(ctrl1), 16'(P_HAZ));
      tick();
      chk("load_stall_cnt", 16'(stall0), 16'd2);
      chk("load_stall_cnt_fwd", 16'(stall1), 16'd1);
      clearIn();

      // MDU op completes on the 4th wait cycle.
      isMdu = 1'b1; regWrite = 1'b1; rd = 5'd3;
      #2;
      chk("mdu_launch", 16'(ctrl0), 16'(P_LAUNCH));
      tick();
      for (int i = 1; i <= 3; i++) begin
         #2;
         chk($sformatf("mdu_hold%0d", i), 16'(ctrl0), 16'(P_HOLD));
         tick();
      end
      mduDone = 1'b1;
      #2;
      chk("mdu_done_release", 16'(ctrl0), 16'(P_RUN));
      tick();
      chk("mdu_stall_cnt", 16'(stall0), 16'd6);
      chk("mdu_stall_cnt_fwd", 16'(stall1), 16'd5);
      clearIn();
      mduDone = 1'b1;
      #2;
      chk("done_in_run_ignored", 16'(ctrl0), 16'(P_RUN));
      tick();
      clearIn();

      // Branch during MDU_WAIT with a pending load-use hazard.
      isMdu = 1'b1;
      #2;
      chk("br_launch", 16'(ctrl0), 16'(P_LAUNCH));
      tick();
      brTaken = 1'b1; mduDone = 1'b1;
      regWrite = 1'b1; memRead = 1'b1; rd = 5'd5; r1 = 5'd5; usesR1 = 1'b1;
      #2;
      chk("br_flush_wait", 16'(ctrl0), 16'(P_FLUSHW));
      tick();
      chk("br_flush_cnt", 16'(flush0), 16'd1);
      chk("br_stall_cnt", 16'(stall0), 16'd7);
      clearIn();
      #2;
      chk("br_back_to_run", 16'(ctrl0), 16'(P_RUN));
      tick();
      // Branch in RUN beats an MDU launch; no abort outside MDU_WAIT.
      brTaken = 1'b1; isMdu = 1'b1;
      #2;
      chk("br_flush_run", 16'(ctrl0), 16'(P_FLUSH));
      tick();
      chk("br_flush_cnt2", 16'(flush0), 16'd2);
      clearIn();

      // MDU never completes: 8 held cycles, then abort on the 9th.
      isMdu = 1'b1;
      #2;
      chk("to_launch", 16'(ctrl0), 16'(P_LAUNCH));
      tick();
      for (int i = 1; i <= 7; i++) begin
         #2;
         chk($sformatf("to_hold%0d", i), 16'(ctrl0), 16'(P_HOLD));
         tick();
      end
      chk("to_err_before", 16'(err0), 16'd0);
      #2;
      chk("to_abort", 16'(ctrl0), 16'(P_TOUT));
      tick();
      chk("to_err_set", 16'(err0), 16'd1);
      chk("to_stall_sat", 16'(stall0), 16'd15);
      clearIn();
      #2;
      chk("to_back_to_run", 16'(ctrl0), 16'(P_RUN));
      tick();
      tick();
      chk("to_err_sticky", 16'(err0), 16'd1);

      // Reset clears sticky error and counters.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_err", 16'(err0), 16'd0);
      chk("rst2_stall", 16'(stall0), 16'd0);
      chk("rst2_flush", 16'(flush0), 16'd0);

      // Reset in the middle of MDU_WAIT: no abort pulse, back in RUN.
      isMdu = 1'b1;
      tick();
      #2;
      chk("midwait_hold", 16'(ctrl0), 16'(P_HOLD));
      rst = 1'b1;
      #1;
      chk("midwait_rst_noabort", 16'(ctrl0), 16'(P_RUN));
      tick();
      rst = 1'b0;
      clearIn();
      #2;
      chk("midwait_run", 16'(ctrl0), 16'(P_RUN));
      tick();

      // Saturation: 20 consecutive ALU-dependency stalls on a 4-bit counter.
      regWrite = 1'b1; rd = 5'd9; r1 = 5'd9; usesR1 = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", 16'(stall0), 16'd15);
      chk("sat_stall_fwd", 16'(stall1), 16'd0);
      tick();
      chk("sat_hold", 16'(stall0), 16'd15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sat_rst", 16'(stall0), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
